// File: rtl/chan_mux_seq.sv
// Registered N-channel, W-bit multiplexer with manual select and auto-scan modes.
// Provides hold, a valid flag that drops for one settling cycle per mode change, and a scan-wrap pulse.
module chan_mux_seq #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int DWELL    = 4,
    localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    input  logic                      hold,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          chan_out,
    output logic                      valid,
    output logic                      wrap
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   NUM_CH  = (SEL_W + 1)'(CHANNELS);
    localparam logic [7:0]       LAST_DW = 8'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  ptr, ptr_nxt;
    logic [7:0]        dcnt, dcnt_nxt;
    logic [SEL_W-1:0]  man_idx;
    logic [SEL_W-1:0]  show_idx;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  data_nxt;
    logic [SEL_W-1:0]  chan_nxt;
    logic              valid_nxt;
    logic              wrap_nxt;

    // Legacy inverted mapping; out-of-range selects fall back to channel 0.
    always_comb begin
        man_idx = '0;
        if ({1'b0, select} < NUM_CH) begin
            man_idx = LAST_CH - select;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (SEL_W'(k) == show_idx) begin
                sel_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state, scan pointer and output selection.
    // data_out shows the post-update pointer so wrap and channel 0 land on the same cycle.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        dcnt_nxt  = dcnt;
        show_idx  = chan_out;
        wrap_nxt  = 1'b0;
        valid_nxt = (state != IDLE);
        data_nxt  = data_out;
        chan_nxt  = chan_out;

        if (!hold) begin
            state_nxt = mode ? SCAN : MANUAL;
            if (state_nxt == SCAN) begin
                if (state != SCAN) begin
                    ptr_nxt  = '0;
                    dcnt_nxt = '0;
                end else if (dcnt == LAST_DW) begin
                    dcnt_nxt = '0;
                    if (ptr == LAST_CH) begin
                        ptr_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        ptr_nxt = ptr + SEL_W'(1);
                    end
                end else begin
                    dcnt_nxt = dcnt + 8'd1;
                end
                show_idx = ptr_nxt;
            end else begin
                show_idx = man_idx;
            end
            valid_nxt = (state_nxt == state);
            data_nxt  = sel_data;
            chan_nxt  = show_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            dcnt     <= '0;
            data_out <= '0;
            chan_out <= '0;
            valid    <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            ptr      <= ptr_nxt;
            dcnt     <= dcnt_nxt;
            data_out <= data_nxt;
            chan_out <= chan_nxt;
            valid    <= valid_nxt;
            wrap     <= wrap_nxt;
        end
    end

endmodule
